// File: rtl/rtc_edit_pkg.sv
// Shared constants for the RTC edit controller: field indices, group codes,
// per-field BCD limits, FSM state encoding, and small lookup helpers.
// Pure declarations, no logic or state.
package rtc_edit_pkg;

    // Field index f; f = 0 is DD (bits [71:64]) ... f = 8 is TimerSEG (bits [7:0])
    localparam logic [3:0] F_DD    = 4'd0;
    localparam logic [3:0] F_M     = 4'd1;
    localparam logic [3:0] F_AN    = 4'd2;
    localparam logic [3:0] F_HORA  = 4'd3;
    localparam logic [3:0] F_MIN   = 4'd4;
    localparam logic [3:0] F_SEG   = 4'd5;
    localparam logic [3:0] F_THORA = 4'd6;
    localparam logic [3:0] F_TMIN  = 4'd7;
    localparam logic [3:0] F_TSEG  = 4'd8;

    // Group encodings, shared with mode_sel and wr_group
    localparam logic [1:0] G_NONE  = 2'd0;
    localparam logic [1:0] G_FECHA = 2'd1;
    localparam logic [1:0] G_HORA  = 2'd2;
    localparam logic [1:0] G_TIMER = 2'd3;

    // Legal BCD ranges; timer fields reuse the time-of-day limits
    localparam logic [7:0] DD_MIN   = 8'h01;
    localparam logic [7:0] DD_MAX   = 8'h31;
    localparam logic [7:0] M_MIN    = 8'h01;
    localparam logic [7:0] M_MAX    = 8'h12;
    localparam logic [7:0] AN_MIN   = 8'h00;
    localparam logic [7:0] AN_MAX   = 8'h99;
    localparam logic [7:0] HORA_MIN = 8'h00;
    localparam logic [7:0] HORA_MAX = 8'h23;
    localparam logic [7:0] MS_MIN   = 8'h00;
    localparam logic [7:0] MS_MAX   = 8'h59;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EDIT     = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_WAIT_ACK = 2'd3
    } state_t;

    function automatic logic [7:0] field_min(input logic [3:0] f);
        case (f)
            F_DD:    return DD_MIN;
            F_M:     return M_MIN;
            F_AN:    return AN_MIN;
            default: return MS_MIN;
        endcase
    endfunction

    function automatic logic [7:0] field_max(input logic [3:0] f);
        case (f)
            F_DD:            return DD_MAX;
            F_M:             return M_MAX;
            F_AN:            return AN_MAX;
            F_HORA, F_THORA: return HORA_MAX;
            default:         return MS_MAX;
        endcase
    endfunction

    function automatic logic [3:0] group_first(input logic [1:0] g);
        case (g)
            G_HORA:  return F_HORA;
            G_TIMER: return F_THORA;
            default: return F_DD;
        endcase
    endfunction

endpackage

// File: rtl/rtc_edit_ctrl_bcd_step.sv
// One-step BCD increment/decrement with wrap between min and max.
// Combinational, zero latency; no handshake.
// Invalid BCD or out-of-range input snaps to min instead of stepping.
module bcd_step (
    input  logic [7:0] value,
    input  logic [7:0] min,
    input  logic [7:0] max,
    input  logic       dir,
    output logic [7:0] next
);

    logic valid;

    // Validate the input, then step up (dir=1) or down (dir=0) with decimal carry/borrow
    always_comb begin
        valid = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) &&
                (value >= min) && (value <= max);
        next  = min;
        if (valid) begin
            if (dir) begin
                if (value == max)
                    next = min;
                else if (value[3:0] == 4'd9)
                    next = {value[7:4] + 4'd1, 4'd0};
                else
                    next = value + 8'd1;
            end else begin
                if (value == min)
                    next = max;
                else if (value[3:0] == 4'd0)
                    next = {value[7:4] - 4'd1, 4'd9};
                else
                    next = value - 8'd1;
            end
        end
    end

endmodule

// File: rtl/rtc_edit_ctrl.sv
// Edit/cursor controller: snapshots RTC fields, edits one group, commits via req/ack.
// All outputs registered, latency 1 cycle from the triggering input.
// wr_req held until wr_ack or ACK_TIMEOUT; buttons ignored while committing.
module rtc_edit_ctrl
    import rtc_edit_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1023,
    parameter int TO_W        = 10
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  mode_sel,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_enter,
    input  logic [71:0] rtc_fields_in,
    input  logic        wr_ack,
    output logic [71:0] edit_fields,
    output logic [8:0]  bandera_cursor,
    output logic        wr_req,
    output logic [1:0]  wr_group,
    output logic        busy,
    output logic        err_timeout
);

    state_t          state;
    logic [1:0]      grp;
    logic [3:0]      cur_f;
    logic [TO_W-1:0] to_cnt;

    logic [3:0]      first_f;
    logic [3:0]      last_f;
    logic [3:0]      right_f;
    logic [3:0]      left_f;
    logic [6:0]      cur_lsb;
    logic [7:0]      cur_val;
    logic [7:0]      cur_min;
    logic [7:0]      cur_max;
    logic [7:0]      step_val;

    // Cursor neighbours within the latched group, and the selected field's value and limits
    always_comb begin
        first_f = group_first(grp);
        last_f  = first_f + 4'd2;
        right_f = (cur_f == last_f)  ? first_f : cur_f + 4'd1;
        left_f  = (cur_f == first_f) ? last_f  : cur_f - 4'd1;
        cur_lsb = {4'd8 - cur_f, 3'b000};
        cur_val = edit_fields[cur_lsb +: 8];
        cur_min = field_min(cur_f);
        cur_max = field_max(cur_f);
    end

    // Up wins over down when both are pressed, matching the button priority
    bcd_step u_step (
        .value (cur_val),
        .min   (cur_min),
        .max   (cur_max),
        .dir   (btn_up),
        .next  (step_val)
    );

    // Main FSM: snapshot/track, cursor and field edits, commit handshake with timeout
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= ST_IDLE;
            grp            <= G_NONE;
            cur_f          <= 4'd0;
            to_cnt         <= '0;
            edit_fields    <= '0;
            bandera_cursor <= '0;
            wr_req         <= 1'b0;
            wr_group       <= G_NONE;
            busy           <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    edit_fields    <= rtc_fields_in;
                    bandera_cursor <= '0;
                    if (btn_enter && (mode_sel != G_NONE)) begin
                        state          <= ST_EDIT;
                        busy           <= 1'b1;
                        grp            <= mode_sel;
                        cur_f          <= group_first(mode_sel);
                        bandera_cursor <= 9'h100 >> group_first(mode_sel);
                    end
                end
                ST_EDIT: begin
                    // A mode change abandons the edit without writing anything
                    if (mode_sel != grp) begin
                        state          <= ST_IDLE;
                        busy           <= 1'b0;
                        bandera_cursor <= '0;
                    end else if (btn_enter) begin
                        state <= ST_COMMIT;
                    end else if (btn_up || btn_down) begin
                        edit_fields[cur_lsb +: 8] <= step_val;
                    end else if (btn_right) begin
                        cur_f          <= right_f;
                        bandera_cursor <= 9'h100 >> right_f;
                    end else if (btn_left) begin
                        cur_f          <= left_f;
                        bandera_cursor <= 9'h100 >> left_f;
                    end
                end
                ST_COMMIT: begin
                    wr_req   <= 1'b1;
                    wr_group <= grp;
                    to_cnt   <= '0;
                    state    <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // An ack arriving on the timeout cycle still counts as success
                    if (wr_ack) begin
                        state          <= ST_IDLE;
                        wr_req         <= 1'b0;
                        busy           <= 1'b0;
                        bandera_cursor <= '0;
                    end else if (to_cnt == TO_W'(ACK_TIMEOUT)) begin
                        state          <= ST_IDLE;
                        wr_req         <= 1'b0;
                        busy           <= 1'b0;
                        bandera_cursor <= '0;
                        err_timeout    <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
// Directed bench for rtc_edit_ctrl with a short ack timeout.
// Inputs driven and outputs sampled on the falling clock edge.
// Each task checks one feature inline and steps the shared counters.
module tb_rtc_edit_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  mode_sel;
    logic        btn_up, btn_down, btn_left, btn_right, btn_enter;
    logic [71:0] rtc_fields_in;
    logic        wr_ack;
    logic [71:0] edit_fields;
    logic [8:0]  bandera_cursor;
    logic        wr_req;
    logic [1:0]  wr_group;
    logic        busy;
    logic        err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    rtc_edit_ctrl #(.ACK_TIMEOUT(8), .TO_W(4)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .mode_sel       (mode_sel),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .btn_enter      (btn_enter),
        .rtc_fields_in  (rtc_fields_in),
        .wr_ack         (wr_ack),
        .edit_fields    (edit_fields),
        .bandera_cursor (bandera_cursor),
        .wr_req         (wr_req),
        .wr_group       (wr_group),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    always #5 CLK = ~CLK;

    function automatic logic [71:0] pack9(input logic [7:0] a, b, c, d, e, f, g, h, i);
        return {a, b, c, d, e, f, g, h, i};
    endfunction

    function automatic logic [7:0] fld(input logic [71:0] v, input int f);
        return v[(8 - f) * 8 +: 8];
    endfunction

    // One-cycle button pulse: set on a falling edge, cleared on the next
    task automatic pulse(input logic u, input logic d, input logic l, input logic r, input logic e);
        @(negedge CLK);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_enter = e;
        @(negedge CLK);
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_enter = 0;
    endtask

    task automatic test_reset;
        RESET = 1; mode_sel = 0; wr_ack = 0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_enter = 0;
        rtc_fields_in = pack9(8'h15, 8'h06, 8'h24, 8'h12, 8'h34, 8'h56, 8'h01, 8'h02, 8'h03);
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({wr_req, busy, err_timeout, wr_group} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {wr_req, busy, err_timeout, wr_group});
        end
        n_cmp++;
        if (edit_fields !== 72'h0) begin
            n_bad++; $display("FAIL reset_fields: got %h want 0", edit_fields);
        end
        n_cmp++;
        if (bandera_cursor !== 9'h000) begin
            n_bad++; $display("FAIL reset_cursor: got %h want 000", bandera_cursor);
        end
        RESET = 0;
        @(negedge CLK);
        n_cmp++;
        if (edit_fields !== rtc_fields_in) begin
            n_bad++; $display("FAIL idle_track: got %h want %h", edit_fields, rtc_fields_in);
        end
    endtask

    task automatic test_fecha;
        rtc_fields_in = pack9(8'h15, 8'h06, 8'h24, 8'h12, 8'h34, 8'h56, 8'h01, 8'h02, 8'h03);
        mode_sel = 1;
        pulse(0, 0, 0, 0, 1);
        n_cmp++;
        if (bandera_cursor !== 9'h100 || fld(edit_fields, 0) !== 8'h15 || busy !== 1'b1) begin
            n_bad++; $display("FAIL fecha_enter: cursor %h dd %h busy %b want 100 15 1",
                              bandera_cursor, fld(edit_fields, 0), busy);
        end
        rtc_fields_in = pack9(8'h20, 8'h07, 8'h25, 8'h13, 8'h35, 8'h57, 8'h02, 8'h03, 8'h04);
        @(negedge CLK);
        n_cmp++;
        if (fld(edit_fields, 0) !== 8'h15) begin
            n_bad++; $display("FAIL fecha_frozen: got %h want 15", fld(edit_fields, 0));
        end
        for (int i = 0; i < 16; i++) pulse(1, 0, 0, 0, 0);
        n_cmp++;
        if (fld(edit_fields, 0) !== 8'h31) begin
            n_bad++; $display("FAIL dd_max: got %h want 31", fld(edit_fields, 0));
        end
        pulse(1, 0, 0, 0, 0);
        n_cmp++;
        if (fld(edit_fields, 0) !== 8'h01 || fld(edit_fields, 1) !== 8'h06) begin
            n_bad++; $display("FAIL dd_wrap: dd %h m %h want 01 06", fld(edit_fields, 0), fld(edit_fields, 1));
        end
        mode_sel = 0;
        @(negedge CLK);
        n_cmp++;
        if (busy !== 1'b0 || bandera_cursor !== 9'h000 || wr_req !== 1'b0) begin
            n_bad++; $display("FAIL fecha_abort: busy %b cursor %h req %b want 0 000 0", busy, bandera_cursor, wr_req);
        end
    endtask

    task automatic test_hora_cursor_bounds;
        logic [8:0] exp_cur [5];
        logic [4:0] moves;
        exp_cur[0] = 9'h020; exp_cur[1] = 9'h010; exp_cur[2] = 9'h008;
        exp_cur[3] = 9'h020; exp_cur[4] = 9'h008;
        moves = 5'b10000;
        rtc_fields_in = pack9(8'h01, 8'h01, 8'h00, 8'h23, 8'h7A, 8'h59, 8'h00, 8'h00, 8'h00);
        mode_sel = 2;
        @(negedge CLK);
        pulse(0, 0, 0, 0, 1);
        n_cmp++;
        if (bandera_cursor !== exp_cur[0]) begin
            n_bad++; $display("FAIL hora_enter: got %h want %h", bandera_cursor, exp_cur[0]);
        end
        for (int i = 1; i < 5; i++) begin
            pulse(0, 0, moves[i], !moves[i], 0);
            n_cmp++;
            if (bandera_cursor !== exp_cur[i]) begin
                n_bad++; $display("FAIL cursor_step%0d: got %h want %h", i, bandera_cursor, exp_cur[i]);
            end
        end
        pulse(1, 0, 0, 0, 0);
        n_cmp++;
        if (fld(edit_fields, 5) !== 8'h00) begin
            n_bad++; $display("FAIL seg_wrap_up: got %h want 00", fld(edit_fields, 5));
        end
        pulse(0, 0, 1, 0, 0);
        pulse(1, 0, 0, 0, 0);
        n_cmp++;
        if (fld(edit_fields, 4) !== 8'h00) begin
            n_bad++; $display("FAIL min_invalid: got %h want 00", fld(edit_fields, 4));
        end
        pulse(0, 0, 1, 0, 0);
        pulse(1, 0, 0, 0, 0);
        n_cmp++;
        if (fld(edit_fields, 3) !== 8'h00) begin
            n_bad++; $display("FAIL hora_wrap_up: got %h want 00", fld(edit_fields, 3));
        end
        pulse(0, 1, 0, 0, 0);
        n_cmp++;
        if (fld(edit_fields, 3) !== 8'h23) begin
            n_bad++; $display("FAIL hora_wrap_down: got %h want 23", fld(edit_fields, 3));
        end
        @(negedge CLK);
        mode_sel = 1;
        @(negedge CLK);
        n_cmp++;
        if (bandera_cursor !== 9'h000 || busy !== 1'b0) begin
            n_bad++; $display("FAIL mode_abort: cursor %h busy %b want 000 0", bandera_cursor, busy);
        end
        @(negedge CLK);
        n_cmp++;
        if (wr_req !== 1'b0) begin
            n_bad++; $display("FAIL abort_no_req: got %b want 0", wr_req);
        end
        mode_sel = 0;
    endtask

    task automatic test_month;
        rtc_fields_in = pack9(8'h10, 8'h01, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        mode_sel = 1;
        @(negedge CLK);
        pulse(0, 0, 0, 0, 1);
        pulse(0, 0, 0, 1, 0);
        n_cmp++;
        if (bandera_cursor !== 9'h080) begin
            n_bad++; $display("FAIL month_cursor: got %h want 080", bandera_cursor);
        end
        pulse(0, 1, 0, 0, 0);
        n_cmp++;
        if (fld(edit_fields, 1) !== 8'h12) begin
            n_bad++; $display("FAIL month_wrap_down: got %h want 12", fld(edit_fields, 1));
        end
        mode_sel = 0;
        @(negedge CLK);
    endtask

    task automatic test_commit;
        rtc_fields_in = pack9(8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h30, 8'h45);
        mode_sel = 3;
        @(negedge CLK);
        pulse(0, 0, 0, 0, 1);
        n_cmp++;
        if (bandera_cursor !== 9'h004) begin
            n_bad++; $display("FAIL timer_enter: got %h want 004", bandera_cursor);
        end
        pulse(1, 0, 0, 1, 0);
        n_cmp++;
        if (fld(edit_fields, 6) !== 8'h06 || bandera_cursor !== 9'h004) begin
            n_bad++; $display("FAIL up_over_right: th %h cursor %h want 06 004", fld(edit_fields, 6), bandera_cursor);
        end
        pulse(0, 0, 0, 0, 1);
        n_cmp++;
        if (wr_req !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL commit_state: req %b busy %b want 0 1", wr_req, busy);
        end
        @(negedge CLK);
        n_cmp++;
        if (wr_req !== 1'b1 || wr_group !== 2'd3) begin
            n_bad++; $display("FAIL commit_req: req %b group %0d want 1 3", wr_req, wr_group);
        end
        @(negedge CLK); btn_up = 1;
        @(negedge CLK); btn_up = 0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (wr_req !== 1'b1 || fld(edit_fields, 6) !== 8'h06 || bandera_cursor !== 9'h004) begin
            n_bad++; $display("FAIL wait_hold: req %b th %h cursor %h want 1 06 004",
                              wr_req, fld(edit_fields, 6), bandera_cursor);
        end
        wr_ack = 1;
        @(negedge CLK);
        wr_ack = 0;
        n_cmp++;
        if (wr_req !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0 || bandera_cursor !== 9'h000) begin
            n_bad++; $display("FAIL ack_done: req %b busy %b err %b cursor %h want 0 0 0 000",
                              wr_req, busy, err_timeout, bandera_cursor);
        end
        rtc_fields_in = pack9(8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10);
        @(negedge CLK);
        n_cmp++;
        if (edit_fields !== rtc_fields_in) begin
            n_bad++; $display("FAIL resume_track: got %h want %h", edit_fields, rtc_fields_in);
        end
        mode_sel = 0;
    endtask

    task automatic test_timeout;
        int early;
        early = 0;
        mode_sel = 3;
        @(negedge CLK);
        pulse(0, 0, 0, 0, 1);
        pulse(0, 0, 0, 0, 1);
        @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (err_timeout !== 1'b0 || wr_req !== 1'b1) early++;
        end
        n_cmp++;
        if (early != 0) begin
            n_bad++; $display("FAIL timeout_early: %0d bad cycles want 0", early);
        end
        @(negedge CLK);
        n_cmp++;
        if (err_timeout !== 1'b1 || wr_req !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL timeout_fire: err %b req %b busy %b want 1 0 0", err_timeout, wr_req, busy);
        end
        @(negedge CLK);
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_bad++; $display("FAIL timeout_pulse: got %b want 0", err_timeout);
        end
        pulse(0, 0, 0, 0, 1);
        pulse(0, 0, 0, 0, 1);
        @(negedge CLK);
        repeat (8) @(negedge CLK);
        wr_ack = 1;
        @(negedge CLK);
        wr_ack = 0;
        n_cmp++;
        if (err_timeout !== 1'b0 || wr_req !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL ack_at_timeout: err %b req %b busy %b want 0 0 0", err_timeout, wr_req, busy);
        end
        @(negedge CLK);
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_bad++; $display("FAIL ack_at_timeout_after: got %b want 0", err_timeout);
        end
        mode_sel = 0;
    endtask

    task automatic test_reset_mid;
        mode_sel = 2;
        @(negedge CLK);
        pulse(0, 0, 0, 0, 1);
        pulse(0, 0, 0, 0, 1);
        @(negedge CLK);
        n_cmp++;
        if (wr_req !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset_req: got %b want 1", wr_req);
        end
        #2 RESET = 1;
        #1;
        n_cmp++;
        if ({wr_req, busy, err_timeout, wr_group} !== 5'b0 || bandera_cursor !== 9'h000 || edit_fields !== 72'h0) begin
            n_bad++; $display("FAIL async_reset: ctrl %b cursor %h fields %h want 0 0 0",
                              {wr_req, busy, err_timeout, wr_group}, bandera_cursor, edit_fields);
        end
        @(negedge CLK);
        RESET = 0;
        mode_sel = 0;
        @(negedge CLK);
        n_cmp++;
        if (wr_req !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL post_reset: req %b busy %b want 0 0", wr_req, busy);
        end
    endtask

    initial begin
        test_reset();
        test_fecha();
        test_hora_cursor_bounds();
        test_month();
        test_commit();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
